// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares one fifo_core write port among NUM_REQ requesters. Grants rotate
// round-robin. Each grant admits up to BURST_MAX words, then the arbiter passes
// through one IDLE cycle before it issues the next grant.
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   req              in   [NUM_REQ]        per-requester "word offered"
//   req_data         in   [NUM_REQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   gnt              out  [NUM_REQ]        registered one-hot grant, 0 when idle
//   owner            out  [OWNER_W]        registered owner index, 0 when idle
//   busy             out                   high while in BURST
//   fifo_count       in   [POINTER_WIDTH+1] fifo_core occupancy
//   fifo_wr_en       out                   registered write strobe to fifo_core
//   fifo_input_data  out  [WIDTH]          registered write data to fifo_core
//   state_dbg        out                   FSM state (0 = IDLE, 1 = BURST)
//
// Handshake: a word from the owner is taken on a rising edge where
// req[owner]=1 and the FIFO has room. Room counts the occupancy plus the
// registered write still in flight. On the next cycle that word appears on
// fifo_input_data, and fifo_wr_en is high for that one cycle only. The
// requester must hold req and its data until the word is taken. It may drop
// req at any time, and that ends its burst.
//
// Build option: define FIFO_WR_ARB_RESERVE_EN to hold back new grants until
// the FIFO has room for a full BURST_MAX burst, so a burst never stalls.
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int POINTER_WIDTH = 4,
  parameter int BURST_MAX     = 4,
  localparam int OWNER_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BEAT_W       = $clog2(BURST_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [OWNER_W-1:0]       owner,
  output logic                     busy,
  input  logic [POINTER_WIDTH:0]   fifo_count,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_input_data,
  output logic                     state_dbg
);

  // Fill arithmetic is one bit wider than fifo_count so that a full FIFO
  // plus an in-flight write cannot wrap.
  localparam int FILL_W = POINTER_WIDTH + 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_owner_q, last_owner_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                 fifo_wr_en_q, fifo_wr_en_d;
  logic [WIDTH-1:0]     fifo_input_data_q, fifo_input_data_d;

  logic [WIDTH-1:0]     req_word [NUM_REQ];
  logic [FILL_W-1:0]    fill;
  logic                 space;
  logic                 grant_ok;
  logic [OWNER_W-1:0]   winner;
  logic [BEAT_W-1:0]    beat_inc;

  // Round-robin search that starts just above the previous owner.
  function automatic logic [OWNER_W-1:0] pick_winner(
    input logic [NUM_REQ-1:0] r,
    input logic [OWNER_W-1:0] last
  );
    logic [OWNER_W-1:0] win;
    logic [OWNER_W-1:0] idx;
    logic               found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = OWNER_W'((int'(last) + k) % NUM_REQ);
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return win;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // The registered write still in flight has not reached fifo_count yet,
  // so it is added here.
  assign fill   = FILL_W'(fifo_count) + FILL_W'(fifo_wr_en_q);
  assign space  = (fill < FILL_W'(DEPTH));
  assign winner = pick_winner(req, last_owner_q);

`ifdef FIFO_WR_ARB_RESERVE_EN
  assign grant_ok = (fill <= FILL_W'(DEPTH - BURST_MAX));
`else
  assign grant_ok = 1'b1;
`endif

  assign beat_inc = beat_cnt_q + BEAT_W'(1);

  always_comb begin
    state_d           = state_q;
    gnt_d             = gnt_q;
    owner_d           = owner_q;
    last_owner_d      = last_owner_q;
    beat_cnt_d        = beat_cnt_q;
    fifo_wr_en_d      = 1'b0;
    fifo_input_data_d = fifo_input_data_q;

    case (state_q)
      IDLE: begin
        if ((|req) && grant_ok) begin
          state_d    = BURST;
          gnt_d      = NUM_REQ'(1) << winner;
          owner_d    = winner;
          beat_cnt_d = '0;
        end
      end

      BURST: begin
        if (!req[owner_q]) begin
          state_d      = IDLE;
          gnt_d        = '0;
          owner_d      = '0;
          last_owner_d = owner_q;
        end else if (space) begin
          fifo_wr_en_d      = 1'b1;
          fifo_input_data_d = req_word[owner_q];
          beat_cnt_d        = beat_inc;
          if (beat_inc == BEAT_W'(BURST_MAX)) begin
            state_d      = IDLE;
            gnt_d        = '0;
            owner_d      = '0;
            last_owner_d = owner_q;
          end
        end
        // The owner has a word but the FIFO is full, so everything holds.
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        owner_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      gnt_q             <= '0;
      owner_q           <= '0;
      last_owner_q      <= OWNER_W'(NUM_REQ - 1);
      beat_cnt_q        <= '0;
      fifo_wr_en_q      <= 1'b0;
      fifo_input_data_q <= '0;
    end else begin
      state_q           <= state_d;
      gnt_q             <= gnt_d;
      owner_q           <= owner_d;
      last_owner_q      <= last_owner_d;
      beat_cnt_q        <= beat_cnt_d;
      fifo_wr_en_q      <= fifo_wr_en_d;
      fifo_input_data_q <= fifo_input_data_d;
    end
  end

  assign gnt             = gnt_q;
  assign owner           = owner_q;
  assign busy            = (state_q == BURST);
  assign fifo_wr_en      = fifo_wr_en_q;
  assign fifo_input_data = fifo_input_data_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Testbench for fifo_wr_arbiter. A cycle-level reference model predicts the
// visible outputs after each rising edge. An expected-word queue checks every
// word the DUT writes. Directed scenarios cover a single burst, round-robin
// order, FIFO-full stall (or grant reservation when FIFO_WR_ARB_RESERVE_EN is
// defined), an early drop, a drop on grant and reset mid-burst. A randomized
// phase follows, with an emulated FIFO that drains at random.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int WIDTH         = 8;
  localparam int DEPTH         = 16;
  localparam int POINTER_WIDTH = 4;
  localparam int BURST_MAX     = 4;
  localparam int OWNER_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W         = POINTER_WIDTH + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic [OWNER_W-1:0]       owner;
  logic                     busy;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_input_data;
  logic                     state_dbg;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .POINTER_WIDTH(POINTER_WIDTH), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .gnt(gnt), .owner(owner), .busy(busy), .fifo_count(fifo_count),
    .fifo_wr_en(fifo_wr_en), .fifo_input_data(fifo_input_data),
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit               m_busy;
  int               m_owner;
  int               m_last;
  int               m_beats;
  bit               m_wr_en;
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] exp_q[$];

  int grant_log[$];
  int n_writes;
  bit prev_busy;

  // requester sources: each offers src_left words, base + index
  int src_left[NUM_REQ];
  int src_base[NUM_REQ];
  int src_idx[NUM_REQ];

  int               drive_mode;   // 0 sources, 1 random, 2 fixed_req
  logic [NUM_REQ-1:0] fixed_req;
  logic [NUM_REQ-1:0] rnd_req;
  bit               cnt_emul;
  int               fixed_cnt;
  int               occ;
  bit               pend_wr;

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = NUM_REQ - 1;
    m_beats = 0;
    m_wr_en = 1'b0;
    m_data  = '0;
    exp_q.delete();
  endtask

  task automatic end_burst();
    m_last  = m_owner;
    m_owner = 0;
    m_busy  = 1'b0;
  endtask

  // Advance the model by one rising edge with inputs r, d and FIFO count c.
  task automatic model_step(input logic [NUM_REQ-1:0] r,
                            input logic [NUM_REQ*WIDTH-1:0] d, input int c);
    int fill;
    bit nxt_wr;
    bit ok;
    bit found;
    int i;
    fill   = c + int'(m_wr_en);
    nxt_wr = 1'b0;
    if (!m_busy) begin
      ok = (r != '0);
`ifdef FIFO_WR_ARB_RESERVE_EN
      ok = ok && (fill <= DEPTH - BURST_MAX);
`endif
      if (ok) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          i = (m_last + k) % NUM_REQ;
          if (!found && r[i]) begin
            found   = 1'b1;
            m_owner = i;
          end
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!r[m_owner]) begin
      end_burst();
    end else if (fill < DEPTH) begin
      nxt_wr = 1'b1;
      m_data = d[m_owner*WIDTH +: WIDTH];
      exp_q.push_back(m_data);
      m_beats++;
      if (drive_mode == 0) begin
        src_left[m_owner]--;
        src_idx[m_owner]++;
      end
      if (m_beats == BURST_MAX) end_burst();
    end
    m_wr_en = nxt_wr;
  endtask

  // ---------------- scoreboard / output checks ----------------
  task automatic check_outputs();
    logic [NUM_REQ-1:0] eg;
    eg = m_busy ? (NUM_REQ'(1) << m_owner) : '0;
    chk("gnt", gnt, eg);
    chk("owner", owner, m_owner);
    chk("busy", busy, m_busy);
    chk("state_dbg", state_dbg, m_busy);
    chk("wr_en", fifo_wr_en, m_wr_en);
    chk("wr_data", fifo_input_data, m_data);
    if (fifo_wr_en) begin
      n_writes++;
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("sb_word", fifo_input_data, exp_q.pop_front());
    end
    if (busy && !prev_busy) grant_log.push_back(int'(owner));
    prev_busy = busy;
  endtask

  // ---------------- driver ----------------
  task automatic drive_and_step();
    logic [NUM_REQ-1:0]       r;
    logic [NUM_REQ*WIDTH-1:0] d;
    int c;
    if (cnt_emul) begin
      occ = occ + int'(pend_wr);
      if (occ > 0 && $urandom_range(0, 2) == 0) occ--;
      pend_wr = fifo_wr_en;
      chk("fifo_no_overflow", occ <= DEPTH, 1);
      c = occ;
    end else begin
      c = fixed_cnt;
    end
    r = '0;
    d = '0;
    case (drive_mode)
      0: for (int i = 0; i < NUM_REQ; i++) begin
           r[i] = (src_left[i] > 0);
           d[i*WIDTH +: WIDTH] = WIDTH'(src_base[i] + src_idx[i]);
         end
      1: for (int i = 0; i < NUM_REQ; i++) begin
           if ($urandom_range(0, 3) == 0) rnd_req[i] = ~rnd_req[i];
           r[i] = rnd_req[i];
           d[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         end
      default: for (int i = 0; i < NUM_REQ; i++) begin
           r[i] = fixed_req[i];
           d[i*WIDTH +: WIDTH] = WIDTH'(8'hC0 + i);
         end
    endcase
    req        = r;
    req_data   = d;
    fifo_count = CNT_W'(c);
    model_step(r, d, c);
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    drive_and_step();
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    req   = '0;
    #1;
    chk("rst_async_gnt", gnt, 0);
    chk("rst_async_wr_en", fifo_wr_en, 0);
    model_reset();
    occ       = 0;
    pend_wr   = 1'b0;
    prev_busy = 1'b0;
    n_writes  = 0;
    grant_log.delete();
    repeat (cycles) begin
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_owner", owner, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_data", fifo_input_data, 0);
    end
    reset = 1'b1;
    drive_and_step();
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_left[i] = 0;
      src_base[i] = 0;
      src_idx[i]  = 0;
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rr_exp[5];
    int guard;
    rr_exp     = '{0, 1, 2, 3, 0};
    req        = '0;
    req_data   = '0;
    fifo_count = '0;
    fixed_req  = '0;
    rnd_req    = '0;
    drive_mode = 0;
    cnt_emul   = 1'b0;
    fixed_cnt  = 0;
    clear_sources();
    #2;

    // single four-word burst from requester 0
    src_left[0] = 4;
    src_base[0] = 'hA0;
    apply_reset(3);
    repeat (10) tick();
    chk("single_writes", n_writes, 4);
    chk("single_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) chk("single_owner", grant_log[0], 0);

    // all requesters held: round-robin 0,1,2,3,0
    clear_sources();
    for (int i = 0; i < NUM_REQ; i++) begin
      src_left[i] = 100;
      src_base[i] = 'h10 * (i + 1);
    end
    apply_reset(2);
    repeat (25) tick();
    chk("rr_grants", grant_log.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk("rr_order", grant_log[k], rr_exp[k]);
    chk("rr_writes", n_writes, 20);

`ifndef FIFO_WR_ARB_RESERVE_EN
    // owner 2 stalls on a full FIFO, then resumes
    clear_sources();
    src_left[2] = 100;
    src_base[2] = 'h20;
    fixed_cnt   = 15;
    apply_reset(2);
    tick();
    chk("stall_owner", owner, 2);
    fixed_cnt = 16;
    tick();
    chk("stall_first_write", n_writes, 1);
    repeat (5) begin
      tick();
      chk("stall_gnt", gnt, 4'b0100);
      chk("stall_wr_en", fifo_wr_en, 0);
    end
    fixed_cnt = 15;
    tick();
    tick();
    chk("stall_resume", n_writes, 2);
`else
    // no grant until a full burst fits
    clear_sources();
    src_left[0] = 4;
    src_base[0] = 'h30;
    fixed_cnt   = 13;
    apply_reset(2);
    repeat (5) begin
      tick();
      chk("resv_hold", gnt, 0);
    end
    fixed_cnt = 12;
    tick();
    tick();
    chk("resv_grant", gnt, 4'b0001);
`endif

    // owner 1 drops after two words, requester 3 follows
    clear_sources();
    src_left[1] = 2;
    src_base[1] = 'h50;
    src_left[3] = 4;
    src_base[3] = 'h70;
    fixed_cnt   = 0;
    apply_reset(2);
    repeat (14) tick();
    chk("drop_grants", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      chk("drop_first", grant_log[0], 1);
      chk("drop_second", grant_log[1], 3);
    end
    chk("drop_writes", n_writes, 6);

    // request withdrawn as the grant arrives
    drive_mode = 2;
    fixed_req  = 4'b0100;
    apply_reset(2);
    fixed_req = '0;
    tick();
    chk("wd_gnt", gnt, 4'b0100);
    repeat (4) tick();
    chk("wd_writes", n_writes, 0);
    chk("wd_idle", busy, 0);

    // reset in the cycle after an accept
    drive_mode = 0;
    clear_sources();
    src_left[0] = 100;
    src_base[0] = 'h90;
    apply_reset(2);
    guard = 0;
    while (!m_wr_en && guard < 10) begin
      tick();
      guard++;
    end
    chk("rst_mid_bound", guard < 10, 1);
    @(posedge clk);
    #2;
    chk("rst_mid_pre_wr_en", fifo_wr_en, 1);
    for (int i = 0; i < NUM_REQ; i++) src_left[i] = 100;
    apply_reset(2);
    repeat (3) tick();
    chk("rst_mid_grants", grant_log.size() > 0, 1);
    if (grant_log.size() > 0) chk("rst_mid_first", grant_log[0], 0);

    // randomized traffic against an emulated draining FIFO
    drive_mode = 1;
    cnt_emul   = 1'b1;
    rnd_req    = '0;
    apply_reset(2);
    repeat (800) tick();
    drive_mode = 2;
    fixed_req  = '0;
    repeat (BURST_MAX + 4) tick();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_activity", n_writes > 50, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
